// File: rtl/sram_pkg.sv
// Shared constants for the multiport SRAM family: default geometry and the
// word widths of the graph, working, input and output memories.
package sram_pkg;

    localparam int ADDR_W  = 13;
    localparam int DEPTH   = 8192;

    localparam int GRAPH_W = 128;
    localparam int WORK_W  = 128;
    localparam int IN_W    = 8;
    localparam int OUT_W   = 16;

endpackage

// File: rtl/sram_read_port.sv
// One combinational read port: range-checks the address and muxes the
// addressed word out of the shared array; out-of-range reads return zero.
module sram_read_port #(
    parameter int DATA_W = sram_pkg::GRAPH_W,
    parameter int ADDR_W = sram_pkg::ADDR_W,
    parameter int DEPTH  = sram_pkg::DEPTH
) (
    input  logic [DATA_W-1:0] i_mem [DEPTH],
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    // The low index bits only select a word once the full address is known in range.
    always_comb begin
        o_data = '0;
        if ({1'b0, i_addr} < DEPTH_L) begin
            o_data = i_mem[i_addr[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/sram_multiport.sv
// Parameterised SRAM with up to two combinational read ports and an optional
// clocked write port; the array is never cleared so preloads survive reset.
module sram_multiport #(
    parameter int DATA_W = sram_pkg::GRAPH_W,
    parameter int ADDR_W = sram_pkg::ADDR_W,
    parameter int DEPTH  = sram_pkg::DEPTH,
    parameter int NUM_RD = 2,
    parameter int HAS_WR = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WriteAddress,
    input  logic [DATA_W-1:0] WriteBus,
    input  logic [ADDR_W-1:0] ReadAddress1,
    output logic [DATA_W-1:0] ReadBus1,
    input  logic [ADDR_W-1:0] ReadAddress2,
    output logic [DATA_W-1:0] ReadBus2
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] Register [DEPTH];

    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [DATA_W-1:0] w_rd_data [2];
    logic              w_wr_in_range;

    assign w_rd_addr[0]  = ReadAddress1;
    assign w_rd_addr[1]  = ReadAddress2;
    assign ReadBus1      = w_rd_data[0];
    assign ReadBus2      = w_rd_data[1];
    assign w_wr_in_range = ({1'b0, WriteAddress} < DEPTH_L);

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_rd
            if (g < NUM_RD) begin : g_port
                sram_read_port #(
                    .DATA_W (DATA_W),
                    .ADDR_W (ADDR_W),
                    .DEPTH  (DEPTH)
                ) u_port (
                    .i_mem  (Register),
                    .i_addr (w_rd_addr[g]),
                    .o_data (w_rd_data[g])
                );
            end else begin : g_off
                logic unused_addr;
                assign unused_addr  = ^w_rd_addr[g];
                assign w_rd_data[g] = '0;
            end
        end
    endgenerate

    // No write-through: readers see the new word only after the edge.
    generate
        if (HAS_WR != 0) begin : g_wr
            always_ff @(posedge clock) begin
                if (reset && WE && w_wr_in_range) begin
                    Register[WriteAddress[IDX_W-1:0]] <= WriteBus;
                end
            end
        end else begin : g_no_wr
            logic unused_wr;
            assign unused_wr = ^{reset, WE, w_wr_in_range, WriteAddress, WriteBus};
        end
    endgenerate

endmodule

// File: tb/tb_sram_multiport.sv
// Bench for sram_multiport: a 16-bit 2R1W instance (DEPTH 4096) against an
// array model, plus read-only 8-bit 1R and 128-bit 2R instances preloaded hierarchically.
module tb_sram_multiport;

    localparam int RW_DEPTH = 4096;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        we;
    logic [12:0] wa, ra1, ra2;
    logic [15:0] wd, rd1, rd2;

    logic        ro_we;
    logic [12:0] ro_wa, ro_ra1, ro_ra2;
    logic [7:0]  ro_wd, ro_rd1, ro_rd2;

    logic         gm_we;
    logic [12:0]  gm_wa, gm_ra1, gm_ra2;
    logic [127:0] gm_wd, gm_rd1, gm_rd2;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] model [RW_DEPTH];

    sram_multiport #(.DATA_W(16), .ADDR_W(13), .DEPTH(RW_DEPTH), .NUM_RD(2), .HAS_WR(1)) u_rw (
        .clock(clock), .reset(reset), .WE(we), .WriteAddress(wa), .WriteBus(wd),
        .ReadAddress1(ra1), .ReadBus1(rd1), .ReadAddress2(ra2), .ReadBus2(rd2)
    );

    sram_multiport #(.DATA_W(8), .ADDR_W(13), .DEPTH(8192), .NUM_RD(1), .HAS_WR(0)) u_ro (
        .clock(clock), .reset(reset), .WE(ro_we), .WriteAddress(ro_wa), .WriteBus(ro_wd),
        .ReadAddress1(ro_ra1), .ReadBus1(ro_rd1), .ReadAddress2(ro_ra2), .ReadBus2(ro_rd2)
    );

    sram_multiport #(.DATA_W(128), .ADDR_W(13), .DEPTH(8192), .NUM_RD(2), .HAS_WR(0)) u_gm (
        .clock(clock), .reset(reset), .WE(gm_we), .WriteAddress(gm_wa), .WriteBus(gm_wd),
        .ReadAddress1(gm_ra1), .ReadBus1(gm_rd1), .ReadAddress2(gm_ra2), .ReadBus2(gm_rd2)
    );

    function automatic logic [15:0] ref_rd(input logic [12:0] a);
        return (a < 13'(RW_DEPTH)) ? model[a[11:0]] : 16'h0000;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic preload_rw();
        reset = 1'b1;
        we    = 1'b1;
        for (int i = 0; i < RW_DEPTH; i++) begin
            wa = 13'(i);
            if (i == 'h10)      wd = 16'h0000;
            else if (i == 3)    wd = 16'h0042;
            else                wd = 16'($urandom);
            model[i] = wd;
            step();
        end
        we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        we    = 1'b1;
        wa    = 13'd3;
        wd    = 16'hFFFF;
        ra1   = 13'd3;
        ra2   = 13'd3;
        #1;
        n_cmp++;
        if (rd1 !== 16'h0042) begin
            n_err++;
            $display("FAIL reset_read_pre got=%h exp=%h", rd1, 16'h0042);
        end
        step();
        n_cmp++;
        if (rd1 !== 16'h0042) begin
            n_err++;
            $display("FAIL reset_write_blocked rd1 got=%h exp=%h", rd1, 16'h0042);
        end
        n_cmp++;
        if (rd2 !== 16'h0042) begin
            n_err++;
            $display("FAIL reset_write_blocked rd2 got=%h exp=%h", rd2, 16'h0042);
        end
        for (int k = 0; k < 6; k++) begin
            wa  = 13'($urandom_range(0, RW_DEPTH - 1));
            wd  = 16'($urandom);
            ra1 = wa;
            step();
            n_cmp++;
            if (rd1 !== model[wa[11:0]]) begin
                n_err++;
                $display("FAIL reset_random_blocked addr=%h got=%h exp=%h", wa, rd1, model[wa[11:0]]);
            end
        end
        we    = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_write_read();
        ra1 = 13'h10;
        ra2 = 13'h11;
        wa  = 13'h10;
        wd  = 16'h1234;
        we  = 1'b1;
        #1;
        n_cmp++;
        if (rd1 !== 16'h0000) begin
            n_err++;
            $display("FAIL write_read_before got=%h exp=%h", rd1, 16'h0000);
        end
        step();
        we = 1'b0;
        model['h10] = 16'h1234;
        n_cmp++;
        if (rd1 !== 16'h1234) begin
            n_err++;
            $display("FAIL write_read_after got=%h exp=%h", rd1, 16'h1234);
        end
        n_cmp++;
        if (rd2 !== model['h11]) begin
            n_err++;
            $display("FAIL write_neighbour got=%h exp=%h", rd2, model['h11]);
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] exp_v;
        ra1 = 13'h1800;
        ra2 = 13'h1000;
        #1;
        n_cmp++;
        if (rd1 !== 16'h0000) begin
            n_err++;
            $display("FAIL oor_read_1800 got=%h exp=%h", rd1, 16'h0000);
        end
        n_cmp++;
        if (rd2 !== 16'h0000) begin
            n_err++;
            $display("FAIL oor_read_1000 got=%h exp=%h", rd2, 16'h0000);
        end
        ra2 = 13'h0FFF;
        #1;
        n_cmp++;
        if (rd2 !== model[4095]) begin
            n_err++;
            $display("FAIL last_word_read got=%h exp=%h", rd2, model[4095]);
        end
        exp_v = model['h800];
        ra1   = 13'h0800;
        we    = 1'b1;
        wa    = 13'h1800;
        wd    = ~exp_v;
        step();
        wa = 13'h1000;
        step();
        we = 1'b0;
        n_cmp++;
        if (rd1 !== exp_v) begin
            n_err++;
            $display("FAIL oor_write_alias_800 got=%h exp=%h", rd1, exp_v);
        end
        ra1 = 13'h0000;
        #1;
        n_cmp++;
        if (rd1 !== model[0]) begin
            n_err++;
            $display("FAIL oor_write_alias_000 got=%h exp=%h", rd1, model[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e1, e2;
        for (int it = 0; it < 300; it++) begin
            reset = ($urandom_range(0, 7) != 0);
            we    = 1'($urandom_range(0, 1));
            wa    = ($urandom_range(0, 7) == 0) ? 13'($urandom_range(RW_DEPTH, 8191))
                                               : 13'($urandom_range(0, RW_DEPTH - 1));
            wd    = 16'($urandom);
            ra1   = ($urandom_range(0, 2) == 0) ? wa : 13'($urandom_range(0, 5119));
            ra2   = ($urandom_range(0, 3) == 0) ? ra1 : 13'($urandom_range(0, 5119));
            #1;
            e1 = ref_rd(ra1);
            e2 = ref_rd(ra2);
            n_cmp++;
            if (rd1 !== e1) begin
                n_err++;
                $display("FAIL rand_pre_rd1 it=%0d addr=%h got=%h exp=%h", it, ra1, rd1, e1);
            end
            n_cmp++;
            if (rd2 !== e2) begin
                n_err++;
                $display("FAIL rand_pre_rd2 it=%0d addr=%h got=%h exp=%h", it, ra2, rd2, e2);
            end
            step();
            if (reset && we && (wa < 13'(RW_DEPTH))) model[wa[11:0]] = wd;
            e1 = ref_rd(ra1);
            e2 = ref_rd(ra2);
            n_cmp++;
            if (rd1 !== e1) begin
                n_err++;
                $display("FAIL rand_post_rd1 it=%0d addr=%h got=%h exp=%h", it, ra1, rd1, e1);
            end
            n_cmp++;
            if (rd2 !== e2) begin
                n_err++;
                $display("FAIL rand_post_rd2 it=%0d addr=%h got=%h exp=%h", it, ra2, rd2, e2);
            end
        end
        reset = 1'b1;
        we    = 1'b0;
    endtask

    task automatic test_read_only();
        u_ro.Register[5] = 8'hA5;
        u_ro.Register[6] = 8'h3C;
        ro_ra1 = 13'd5;
        ro_ra2 = 13'd5;
        #1;
        n_cmp++;
        if (ro_rd1 !== 8'hA5) begin
            n_err++;
            $display("FAIL ro_preload_read got=%h exp=%h", ro_rd1, 8'hA5);
        end
        n_cmp++;
        if (ro_rd2 !== 8'h00) begin
            n_err++;
            $display("FAIL ro_port2_zero got=%h exp=%h", ro_rd2, 8'h00);
        end
        ro_ra1 = 13'd6;
        #1;
        n_cmp++;
        if (ro_rd1 !== 8'h3C) begin
            n_err++;
            $display("FAIL ro_addr_change got=%h exp=%h", ro_rd1, 8'h3C);
        end
        reset = 1'b1;
        ro_we = 1'b1;
        ro_wa = 13'd6;
        ro_wd = 8'hFF;
        step();
        ro_we = 1'b0;
        n_cmp++;
        if (ro_rd1 !== 8'h3C) begin
            n_err++;
            $display("FAIL ro_write_ignored got=%h exp=%h", ro_rd1, 8'h3C);
        end
    endtask

    task automatic test_dual_read();
        logic [127:0] v1, v2;
        logic [12:0]  a1, a2;
        u_gm.Register[13'h1FFF] = 128'h1;
        u_gm.Register[0]        = 128'hAA;
        u_gm.Register[1]        = 128'hBB;
        gm_ra1 = 13'h1FFF;
        gm_ra2 = 13'h1FFF;
        #1;
        n_cmp++;
        if (gm_rd1 !== 128'h1) begin
            n_err++;
            $display("FAIL dual_same_rd1 got=%h exp=%h", gm_rd1, 128'h1);
        end
        n_cmp++;
        if (gm_rd2 !== 128'h1) begin
            n_err++;
            $display("FAIL dual_same_rd2 got=%h exp=%h", gm_rd2, 128'h1);
        end
        gm_ra1 = 13'h0;
        gm_ra2 = 13'h1;
        #1;
        n_cmp++;
        if (gm_rd1 !== 128'hAA) begin
            n_err++;
            $display("FAIL dual_diff_rd1 got=%h exp=%h", gm_rd1, 128'hAA);
        end
        n_cmp++;
        if (gm_rd2 !== 128'hBB) begin
            n_err++;
            $display("FAIL dual_diff_rd2 got=%h exp=%h", gm_rd2, 128'hBB);
        end
        for (int k = 0; k < 8; k++) begin
            a1 = 13'($urandom_range(2, 4095));
            a2 = 13'($urandom_range(4096, 8190));
            v1 = {$urandom, $urandom, $urandom, $urandom};
            v2 = {$urandom, $urandom, $urandom, $urandom};
            u_gm.Register[a1] = v1;
            u_gm.Register[a2] = v2;
            gm_ra1 = a1;
            gm_ra2 = a2;
            #1;
            n_cmp++;
            if (gm_rd1 !== v1) begin
                n_err++;
                $display("FAIL dual_rand_rd1 addr=%h got=%h exp=%h", a1, gm_rd1, v1);
            end
            n_cmp++;
            if (gm_rd2 !== v2) begin
                n_err++;
                $display("FAIL dual_rand_rd2 addr=%h got=%h exp=%h", a2, gm_rd2, v2);
            end
        end
    endtask

    initial begin
        reset  = 1'b0;
        we     = 1'b0;
        wa     = '0;
        wd     = '0;
        ra1    = '0;
        ra2    = '0;
        ro_we  = 1'b0;
        ro_wa  = '0;
        ro_wd  = '0;
        ro_ra1 = '0;
        ro_ra2 = '0;
        gm_we  = 1'b0;
        gm_wa  = '0;
        gm_wd  = '0;
        gm_ra1 = '0;
        gm_ra2 = '0;
        step();
        step();
        preload_rw();
        test_reset();
        test_write_read();
        test_out_of_range();
        test_back_to_back();
        test_read_only();
        test_dual_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
